dmi_target_port: RTL and testbench
==================================

# dmi_target_port

Core-side DMI responder: terminates the DMI request/response handshake in the debug clock domain (clk_i) and converts each accepted `dm::dmi_req_t` into a single access on a simple register port with grant and read-valid, then returns a `dm::dmi_resp_t`. It sits between the core-side outputs of the DMI clock-domain crossing and the debug-module register bank. It allows one transaction in flight, has a bounded timeout, and answers illegal ops with an error response.

## Interface
- `TimeoutCycles`, 255: maximum cycles spent in REQ+WAIT before the block aborts with an error response; legal range 1..65535.
- `clk_i` in 1: debug-domain clock; the block has a single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `clear_i` in 1: synchronous abort; returns FSM to IDLE.
- `dmi_req_i` in `dm::dmi_req_t`: addr[6:0], op[1:0], data[31:0].
- `dmi_req_valid_i` in 1 / `dmi_req_ready_o` out 1: request handshake.
- `dmi_resp_o` out `dm::dmi_resp_t`: data[31:0], resp[1:0].
- `dmi_resp_valid_o` out 1 / `dmi_resp_ready_i` in 1: response handshake.
- `reg_req_o` out 1 / `reg_gnt_i` in 1: register access request and grant.
- `reg_we_o` out 1: 1 = write.
- `reg_addr_o` out 7: register address.
- `reg_wdata_o` out 32: write data.
- `reg_rvalid_i` in 1: access complete; for writes it is an acknowledge.
- `reg_rdata_i` in 32: read data, valid with `reg_rvalid_i`.
- `reg_error_i` in 1: access failed, valid with `reg_rvalid_i`.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: `dmi_req_ready_o`=1. On a valid request, latch addr/op/data:
  - op READ (2'b01) or WRITE (2'b10) -> REQ.
  - op NOP (2'b00) -> RESP with data 0 and resp SUCCESS.
  - op 2'b11 -> RESP with data 0 and resp FAILED. No register access is made.
- REQ: `reg_req_o`=1 with stable addr/we/wdata. On `reg_gnt_i` -> WAIT. If `reg_rvalid_i` arrives in the same cycle as the grant, go directly to RESP.
- WAIT: on `reg_rvalid_i` -> RESP.
  - resp = FAILED if `reg_error_i` is 1, else SUCCESS.
  - data = `reg_rdata_i` for reads, 0 for writes.
- RESP: `dmi_resp_valid_o`=1; `dmi_resp_o` is stable until `dmi_resp_ready_i`, then -> IDLE.
- Timeout: the counter clears on request accept and increments every cycle in REQ or WAIT. When it equals `TimeoutCycles`:
  - drop `reg_req_o`;
  - go to RESP with resp FAILED and data 0.
- After a timeout, a late `reg_rvalid_i` is ignored. The register slave guarantees no rvalid for an abandoned access once a new request is granted.
- `reg_rvalid_i` in IDLE, REQ (without grant) or RESP is ignored.
- Response encodings: SUCCESS = 2'b00, FAILED = 2'b10. BUSY (2'b11) is never generated.
- `clear_i`: from any state, next state IDLE, counter 0, all valids low; the response being held is discarded. `clear_i` has priority over every other event in the same cycle.

## Timing
- Reset values: `dmi_req_ready_o`=0 while `rst_ni` is low, 1 in the first cycle after release (IDLE). `dmi_resp_valid_o`=0, `reg_req_o`=0, `reg_we_o`=0, `reg_addr_o`=0, `reg_wdata_o`=0, `dmi_resp_o`=0, counter=0.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Request accepted at edge N -> `reg_req_o` high in cycle N+1.
- Grant with rvalid in cycle N+1 -> `dmi_resp_valid_o` in N+2. Minimum accept-to-response latency for READ/WRITE is 2 cycles; for NOP or illegal op it is 1 cycle.
- Back-to-back throughput: response handshake at edge M -> `dmi_req_ready_o` in M+1. Maximum throughput is one transaction per 3 cycles.
- Timeout: with no grant, the FAILED response is valid exactly `TimeoutCycles`+1 cycles after accept.
- `reg_req_o`, once raised, stays high until grant, timeout or `clear_i`.

## Structure
- `dm_pkg` gains DTM_SUCCESS / DTM_ERR constants (2-bit) if not already present.
- `dm_pkg` gains the FSM state enum `dmi_tgt_state_e`.
- The block reuses the existing `dm::dmi_req_t`, `dm::dmi_resp_t` and `dtm_op_e`.
- Single module, no sub-modules. Counter width is `$clog2(TimeoutCycles+1)`.

## Test plan
- READ addr 0x11, slave grants immediately, rvalid next cycle with rdata 0xDEADBEEF -> response {0xDEADBEEF, 2'b00} exactly 3 cycles after accept.
- WRITE addr 0x10 data 0x1 with `reg_error_i`=1 on rvalid -> `reg_we_o`=1, `reg_wdata_o`=0x1, response {0, 2'b10}.
- NOP, then op 2'b11 -> responses {0, 2'b00} and {0, 2'b10}, with `reg_req_o` never asserted.
- `TimeoutCycles`=4, slave never grants -> `reg_req_o` high for 4 cycles, then FAILED response; a late rvalid is ignored and the next READ completes normally.
- `dmi_resp_ready_i` held low for 10 cycles -> response stable and `dmi_req_ready_o`=0 throughout. Then `clear_i` pulse -> valid drops next cycle and the block returns to IDLE.
- Assert `rst_ni` low while in WAIT -> all outputs return to their reset values immediately (asynchronously). The first cycle after release has `dmi_req_ready_o`=1.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - debug module types shared by the DMI path and the target port
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_ERR     = 2'h2;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef enum logic [1:0] {
        TGT_IDLE,
        TGT_REQ,
        TGT_WAIT,
        TGT_RESP
    } dmi_tgt_state_e;

endpackage

// File: rtl/dmi_target_port.sv
// rtl/dmi_target_port.sv - DMI responder turning one request into one register access
module dmi_target_port
    import dm::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  dmi_req_t    dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    output dmi_resp_t   dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic        reg_req_o,
    input  logic        reg_gnt_i,
    output logic        reg_we_o,
    output logic [6:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_rvalid_i,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_error_i
);

    localparam int unsigned     CntW   = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

    dmi_tgt_state_e  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            ready_q, ready_d;
    logic            we_q, we_d;
    logic [6:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    dmi_resp_t       resp_q, resp_d, done_resp;
    logic            timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TGT_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        resp_d         = resp_q;
        cnt_inc        = cnt_q + CntW'(1);
        timeout        = (cnt_inc == CntMax);
        // Completion payload: writes return zero data, errors map to FAILED.
        done_resp.data = we_q ? 32'h0 : reg_rdata_i;
        done_resp.resp = reg_error_i ? DTM_ERR : DTM_SUCCESS;

        if (clear_i) begin
            state_d = TGT_IDLE;
            cnt_d   = '0;
            resp_d  = '0;
        end else begin
            case (state_q)
                TGT_IDLE: begin
                    if (ready_q && dmi_req_valid_i) begin
                        cnt_d   = '0;
                        addr_d  = dmi_req_i.addr;
                        wdata_d = dmi_req_i.data;
                        we_d    = (dmi_req_i.op == DTM_WRITE);
                        resp_d  = '0;
                        case (dmi_req_i.op)
                            DTM_READ, DTM_WRITE: state_d = TGT_REQ;
                            DTM_NOP:             state_d = TGT_RESP;
                            default: begin
                                state_d     = TGT_RESP;
                                resp_d.resp = DTM_ERR;
                            end
                        endcase
                    end
                end
                TGT_REQ: begin
                    cnt_d = cnt_inc;
                    if (reg_gnt_i && reg_rvalid_i) begin
                        state_d = TGT_RESP;
                        resp_d  = done_resp;
                    end else if (timeout) begin
                        state_d     = TGT_RESP;
                        resp_d      = '0;
                        resp_d.resp = DTM_ERR;
                    end else if (reg_gnt_i) begin
                        state_d = TGT_WAIT;
                    end
                end
                TGT_WAIT: begin
                    cnt_d = cnt_inc;
                    if (reg_rvalid_i) begin
                        state_d = TGT_RESP;
                        resp_d  = done_resp;
                    end else if (timeout) begin
                        state_d     = TGT_RESP;
                        resp_d      = '0;
                        resp_d.resp = DTM_ERR;
                    end
                end
                TGT_RESP: begin
                    if (dmi_resp_ready_i) begin
                        state_d = TGT_IDLE;
                    end
                end
                default: state_d = TGT_IDLE;
            endcase
        end

        // Registered so ready is low throughout reset and follows the next state.
        ready_d = (state_d == TGT_IDLE);
    end

    assign dmi_req_ready_o  = ready_q;
    assign dmi_resp_valid_o = (state_q == TGT_RESP);
    assign dmi_resp_o       = resp_q;
    assign reg_req_o        = (state_q == TGT_REQ);
    assign reg_we_o         = we_q;
    assign reg_addr_o       = addr_q;
    assign reg_wdata_o      = wdata_q;

endmodule

// File: tb/tb_dmi_target_port.sv
// tb/tb_dmi_target_port.sv - directed vector bench for dmi_target_port
module tb_dmi_target_port;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    dm::dmi_req_t  req;
    logic          req_valid;
    logic          req_ready;
    dm::dmi_resp_t resp;
    logic          resp_valid;
    logic          resp_ready;
    logic          reg_req;
    logic          gnt;
    logic          we;
    logic [6:0]    addr;
    logic [31:0]   wdata;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmi_target_port #(.TimeoutCycles(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .clear_i         (clear),
        .dmi_req_i       (req),
        .dmi_req_valid_i (req_valid),
        .dmi_req_ready_o (req_ready),
        .dmi_resp_o      (resp),
        .dmi_resp_valid_o(resp_valid),
        .dmi_resp_ready_i(resp_ready),
        .reg_req_o       (reg_req),
        .reg_gnt_i       (gnt),
        .reg_we_o        (we),
        .reg_addr_o      (addr),
        .reg_wdata_o     (wdata),
        .reg_rvalid_i    (rvalid),
        .reg_rdata_i     (rdata),
        .reg_error_i     (err)
    );

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] wdata;
        int          gnt_cyc;
        int          rv_cyc;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_lat;
        int          exp_req;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
        req.addr  = a;
        req.op    = dm::dtm_op_e'(op);
        req.data  = d;
        req_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int reqs;
        lat  = 0;
        reqs = 0;
        @(negedge clk);
        chk("req_ready_idle", {63'h0, req_ready}, 64'h1);
        drive_req(v.op, v.addr, v.wdata);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                lat = i;
                break;
            end
            if (reg_req) reqs++;
            if (i == 1 && (v.op == 2'b01 || v.op == 2'b10)) begin
                chk("reg_we", {63'h0, we}, {63'h0, v.op == 2'b10});
                chk("reg_addr", {57'h0, addr}, {57'h0, v.addr});
                chk("reg_wdata", {32'h0, wdata}, {32'h0, v.wdata});
            end
            gnt    = (i == v.gnt_cyc);
            rvalid = (i == v.rv_cyc);
            rdata  = v.rdata;
            err    = v.err;
        end
        // A stray rvalid while the response is held must not disturb it.
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h5A5A5A5A;
        err    = 1'b1;
        chk("latency", 64'(lat), 64'(v.exp_lat));
        chk("resp_data", {32'h0, resp.data}, {32'h0, v.exp_data});
        chk("resp_code", {62'h0, resp.resp}, {62'h0, v.exp_resp});
        chk("reg_req_cycles", 64'(reqs), 64'(v.exp_req));
        @(negedge clk);
        chk("resp_held_valid", {63'h0, resp_valid}, 64'h1);
        chk("resp_held", {30'h0, resp}, {30'h0, v.exp_data, v.exp_resp});
        chk("req_ready_busy", {63'h0, req_ready}, 64'h0);
        rvalid     = 1'b0;
        err        = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("resp_valid_drop", {63'h0, resp_valid}, 64'h0);
        chk("req_ready_back", {63'h0, req_ready}, 64'h1);
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        op     addr   wdata         gnt rv rdata         err exp_data      resp  lat req
        vecs[0] = '{2'b01, 7'h11, 32'h0,        1, 2, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2'b00, 3, 1};
        vecs[1] = '{2'b10, 7'h10, 32'h1,        1, 2, 32'hAAAA5555, 1, 32'h0,        2'b10, 3, 1};
        vecs[2] = '{2'b00, 7'h03, 32'h0,        0, 0, 32'h0,        0, 32'h0,        2'b00, 1, 0};
        vecs[3] = '{2'b11, 7'h04, 32'h0,        0, 0, 32'h0,        0, 32'h0,        2'b10, 1, 0};
        vecs[4] = '{2'b01, 7'h05, 32'h0,        1, 1, 32'h0BADF00D, 0, 32'h0BADF00D, 2'b00, 2, 1};
        vecs[5] = '{2'b10, 7'h7F, 32'hFFFFFFFF, 3, 3, 32'h12345678, 0, 32'h0,        2'b00, 4, 3};
        vecs[6] = '{2'b01, 7'h22, 32'h0,        0, 0, 32'h87654321, 0, 32'h0,        2'b10, 5, 4};
        vecs[7] = '{2'b01, 7'h33, 32'h0,        2, 3, 32'hCAFE0001, 0, 32'hCAFE0001, 2'b00, 4, 2};
        vecs[8] = '{2'b01, 7'h44, 32'h0,        1, 3, 32'h11112222, 1, 32'h11112222, 2'b10, 4, 1};

        rst_n      = 1'b0;
        clear      = 1'b0;
        req        = '0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        gnt        = 1'b0;
        rvalid     = 1'b0;
        rdata      = '0;
        err        = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", {63'h0, req_ready}, 64'h0);
        chk("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
        chk("rst_reg_req", {63'h0, reg_req}, 64'h0);
        chk("rst_outputs", {23'h0, we, addr, wdata}, 64'h0);
        chk("rst_resp", {30'h0, resp}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_ready", {63'h0, req_ready}, 64'h1);

        for (int v = 0; v < 9; v++) run_vec(vecs[v]);

        // Response held for 10 cycles, then discarded by clear.
        @(negedge clk);
        drive_req(2'b01, 7'h01, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        gnt       = 1'b1;
        rvalid    = 1'b1;
        rdata     = 32'h13579BDF;
        @(negedge clk);
        gnt    = 1'b0;
        rvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", {63'h0, resp_valid}, 64'h1);
            chk("hold_resp", {30'h0, resp}, {30'h0, 32'h13579BDF, 2'b00});
            chk("hold_ready", {63'h0, req_ready}, 64'h0);
            @(negedge clk);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_valid", {63'h0, resp_valid}, 64'h0);
        chk("clear_ready", {63'h0, req_ready}, 64'h1);
        chk("clear_reg_req", {63'h0, reg_req}, 64'h0);

        // Asynchronous reset while waiting for rvalid.
        @(negedge clk);
        drive_req(2'b10, 7'h2A, 32'h0F0F);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wr_reg_req", {63'h0, reg_req}, 64'h1);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk("wait_reg_req", {63'h0, reg_req}, 64'h0);
        chk("wait_we", {63'h0, we}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req_ready", {63'h0, req_ready}, 64'h0);
        chk("arst_outputs", {22'h0, resp_valid, reg_req, we, addr, wdata}, 64'h0);
        chk("arst_resp", {30'h0, resp}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst_hold_ready", {63'h0, req_ready}, 64'h0);
        @(negedge clk);
        chk("arst_first_ready", {63'h0, req_ready}, 64'h1);
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
